square_unit: RTL and testbench
==============================

Name: square_unit

Overview:
- Iterative integer squarer; the inverse of the square-root datapath.
- Takes an N-bit root and returns root² by accumulating successive odd numbers (1+3+5+…), the same identity the square-root unit walks in the other direction.
- Serves as the reference generator and round-trip partner for the square-root block: root → square → sqrt must return the original root.
- Single start/ready handshake, one result per request, no pipelining across requests.

Parameters:
- ROOT_WIDTH, 8, width of the root operand; square width is 2*ROOT_WIDTH, odd-term register is ROOT_WIDTH+1 bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- root_i  in  ROOT_WIDTH  root operand, sampled only on an accepted start
- start_i  in  1  request strobe, accepted only in IDLE
- square_o  out  2*ROOT_WIDTH  registered result, holds last completed square
- ready_o  out  1  one-cycle pulse, square_o valid and newly updated
- busy_o  out  1  high in CALC and DONE; start_i ignored while high

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, square_o=0, ready_o=0, busy_o=0, internal acc=0, odd=1, cnt=0. Reset overrides everything, including mid-CALC; the in-flight result is discarded and no ready_o is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On start_i=1: cnt<=root_i, acc<=0, odd<=1.
  - If root_i==0 go to DONE; otherwise go to CALC.
  - With start_i=0, remain in IDLE.
- CALC, each cycle:
  - acc<=acc+odd, odd<=odd+2, cnt<=cnt-1.
  - When cnt==1 in this cycle, go to DONE; otherwise remain in CALC.
- DONE: square_o<=acc, ready_o=1 for exactly this cycle, then IDLE next cycle.
- Latency, with start accepted at edge E:
  - root=r>0: ready_o is high during cycle E+r+1; square_o is updated at the edge that ends the last CALC cycle, i.e. when entering DONE.
  - root=0: ready_o is high during cycle E+1; square_o=0.
  - Implementation must register square_o so it changes at DONE entry and is stable while ready_o=1.
- Throughput: a new start_i is accepted in IDLE the cycle after DONE; minimum spacing between results is r+2 cycles.
- start_i during CALC or DONE is ignored and not queued.
- root_i changes after acceptance have no effect.
- Width rules:
  - acc is 2*ROOT_WIDTH bits and never overflows; max (2^N-1)² fits.
  - odd is ROOT_WIDTH+1 bits; its final value 2r+1 ≤ 2^(N+1)-1 fits.
  - No saturation or truncation is needed; overflow is impossible by construction.
- square_o holds its value indefinitely between results; ready_o=0 outside DONE.
- busy_o = (state!=IDLE), combinational from the state register.

Test Plan:
- Reset then root_i=0, start_i pulse → ready_o high 1 cycle later, square_o=0, busy_o high exactly 1 cycle.
- root_i=1 → ready_o at E+2, square_o=1; root_i=12 → ready_o at E+13, square_o=144.
- root_i=255 (max) → ready_o at E+256, square_o=65025 (0xFE01); no wrap.
- root_i=10 accepted, then start_i held high with root_i=3 during CALC → only one ready_o, square_o=100; the next accepted start (in IDLE) gives 9.
- root_i=200 started, rst asserted for 1 cycle at E+50 → no ready_o, square_o=0, busy_o=0, state IDLE; a following root_i=7 gives 49.
- Exhaustive sweep root 0..255 back-to-back, start asserted in every IDLE cycle → every square_o equals root², one ready_o per request, spacing r+2 cycles; results round-trip through the square-root unit to the same root.

Source files
------------

// File: rtl/square_unit.sv
// Iterative integer squarer: accumulates the odd series 1+3+5+... root times.
// One request in flight at a time; result held on square_o between requests.
module square_unit #(
  parameter int unsigned ROOT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROOT_WIDTH-1:0]     root_i,
  input  logic                      start_i,
  output logic [2*ROOT_WIDTH-1:0]   square_o,
  output logic                      ready_o,
  output logic                      busy_o
);

  localparam int unsigned SQ_W  = 2 * ROOT_WIDTH;
  localparam int unsigned ODD_W = ROOT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SQ_W-1:0]         acc_q, acc_d;
  logic [ODD_W-1:0]        odd_q, odd_d;
  logic [ROOT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SQ_W-1:0]         square_q, square_d;
  logic                    ready_q, ready_d;
  logic [SQ_W-1:0]         acc_next;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      odd_q    <= ODD_W'(1);
      cnt_q    <= '0;
      square_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      odd_q    <= odd_d;
      cnt_q    <= cnt_d;
      square_q <= square_d;
      ready_q  <= ready_d;
    end
  end

  assign acc_next = acc_q + SQ_W'(odd_q);

  // Next state; square_o and ready_o are loaded on the edge that enters DONE
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    odd_d    = odd_q;
    cnt_d    = cnt_q;
    square_d = square_q;
    ready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d = root_i;
          acc_d = '0;
          odd_d = ODD_W'(1);
          if (root_i == '0) begin
            state_d  = ST_DONE;
            square_d = '0;
            ready_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_next;
        odd_d = odd_q + ODD_W'(2);
        cnt_d = cnt_q - ROOT_WIDTH'(1);
        if (cnt_q == ROOT_WIDTH'(1)) begin
          state_d  = ST_DONE;
          square_d = acc_next;
          ready_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign square_o = square_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_square_unit.sv
// Self-checking bench for square_unit: directed cases, random requests and a
// full root sweep checked against r*r, a latency of r edges and an integer sqrt.
module tb_square_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  root_i;
  logic        start_i;
  logic [15:0] square_o;
  logic        ready_o;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned cyc = 0;

  square_unit #(.ROOT_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .root_i   (root_i),
    .start_i  (start_i),
    .square_o (square_o),
    .ready_o  (ready_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned x = 0;
    while ((x + 1) * (x + 1) <= v) x++;
    return x;
  endfunction

  // One request from IDLE: expect ready r edges after acceptance and square r*r
  task automatic run_op(input int unsigned r, input string tag);
    int unsigned n = 0;
    root_i  = 8'(r);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    root_i  = 8'($urandom);
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    while (ready_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_lat"}, n, r);
    check({tag, "_sq"}, 32'(square_o), r * r);
    tick();
    check({tag, "_pulse"}, 32'(ready_o), 32'd0);
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
    check({tag, "_hold"}, 32'(square_o), r * r);
  endtask

  initial begin
    int unsigned n;
    int unsigned nready;
    int unsigned last;
    int unsigned r;

    rst     = 1'b1;
    start_i = 1'b0;
    root_i  = 8'd0;
    repeat (3) tick();
    check("rst_sq", 32'(square_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    tick();

    run_op(0, "r0");
    run_op(1, "r1");
    run_op(12, "r12");
    run_op(255, "r255");

    // start held high during CALC with a different root is ignored
    root_i  = 8'd10;
    start_i = 1'b1;
    tick();
    root_i = 8'd3;
    n = 0;
    while (ready_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("hold_lat", n, 32'd10);
    check("hold_sq", 32'(square_o), 32'd100);
    tick();
    n = 0;
    nready = 0;
    while (ready_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("hold_lat2", n, 32'd4);
    check("hold_sq2", 32'(square_o), 32'd9);
    start_i = 1'b0;
    tick();
    tick();

    // reset in the middle of a long calculation discards it
    run_op(12, "pre_rst");
    root_i  = 8'd200;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (49) tick();
    check("mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_sq", 32'(square_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    nready = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ready_o === 1'b1) nready++;
    end
    check("mid_no_ready", nready, 32'd0);
    check("mid_sq_held", 32'(square_o), 32'd0);
    run_op(7, "post_rst");

    // random roots with random idle gaps
    for (int i = 0; i < 20; i++) begin
      run_op($urandom_range(0, 255), "rand");
      repeat ($urandom_range(0, 3)) tick();
    end

    // back-to-back sweep with start asserted every cycle
    root_i  = 8'd0;
    start_i = 1'b1;
    last    = 0;
    for (int k = 0; k < 256; k++) begin
      r = k;
      n = 0;
      while (ready_o !== 1'b1 && n < 600) begin
        tick();
        n++;
      end
      check("sweep_ready", 32'(ready_o), 32'd1);
      check("sweep_sq", 32'(square_o), r * r);
      check("sweep_sqrt", isqrt(32'(square_o)), r);
      if (k > 0) check("sweep_gap", cyc - last, r + 2);
      last   = cyc;
      root_i = 8'(r + 1);
      tick();
    end
    start_i = 1'b0;
    repeat (3) tick();
    check("end_busy", 32'(busy_o), 32'd0);
    check("end_sq", 32'(square_o), 32'd65025);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
